// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN_Two_Layer sequencer.
//  - Default datapath widths (image, filter1, filter2, convolution result).
//  - seq_state_t: the ten states of the sequencer, in execution order.
package cnn_pkg;

  localparam int IMG_W = 4;   // image tap, unsigned
  localparam int F1_W  = 4;   // layer-1 filter tap, signed
  localparam int F2_W  = 10;  // layer-2 filter tap, signed
  localparam int RES_W = 22;  // ConvResult, signed

  typedef enum logic [3:0] {
    S_IDLE,
    S_L1_PRE,
    S_L1_RUN,
    S_L1_FLUSH,
    S_L1_READ,
    S_L2_PRE,
    S_L2_RUN,
    S_L2_FLUSH,
    S_L2_READ,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/cnn_tap_counter.sv
// Saturating tap-index counter.
//  clk, rst_n : clock, synchronous active-low reset
//  clear      : force count to 0 (wins over enable)
//  enable     : advance by one, holding at limit-1
//  limit      : number of taps in the current pass (1..2**CNT_W)
//  count      : current tap index
//  last       : count has reached limit-1
module cnn_tap_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W:0]   limit,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  logic [CNT_W-1:0] count_q, count_d;

  assign last  = ({1'b0, count_q} == (limit - 1'b1));
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !last) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/cnn_two_layer_seq.sv
// Sequencer for the CNN_Two_Layer datapath.
// On an accepted go it prefetches image/filter1 taps from 1-cycle-latency
// memories and streams them under Start1, flushes, raises ReadEn1, streams
// filter2 taps under Start2, flushes, raises ReadEn2, captures ConvResult
// and pulses done. abort (non-IDLE) returns to IDLE at the next edge.
// Ports:
//  clk, rst_n            clock, synchronous active-low reset
//  go, abort             host start request / cancel
//  busy, done            not-IDLE flag / one-cycle completion pulse
//  img/f1/f2 _addr/_rdata tap memory interfaces (sync read, 1-cycle latency)
//  Start1, Image, Filter1, ReadEn1, Start2, Filter2, ReadEn2
//                        datapath controls and registered tap data
//  ConvResult            datapath result
//  result, result_valid  captured result and its validity
module cnn_two_layer_seq #(
  parameter int IMG_W   = cnn_pkg::IMG_W,
  parameter int F1_W    = cnn_pkg::F1_W,
  parameter int F2_W    = cnn_pkg::F2_W,
  parameter int RES_W   = cnn_pkg::RES_W,
  parameter int L1_TAPS = 15,
  parameter int L2_TAPS = 15,
  parameter int ADDR_W  = 4,
  parameter int SETTLE1 = 1,
  parameter int RES_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    go,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_W-1:0]       img_addr,
  input  logic [IMG_W-1:0]        img_rdata,
  output logic [ADDR_W-1:0]       f1_addr,
  input  logic [F1_W-1:0]         f1_rdata,
  output logic [ADDR_W-1:0]       f2_addr,
  input  logic [F2_W-1:0]         f2_rdata,
  output logic                    Start1,
  output logic [IMG_W-1:0]        Image,
  output logic signed [F1_W-1:0]  Filter1,
  output logic                    ReadEn1,
  output logic                    Start2,
  output logic signed [F2_W-1:0]  Filter2,
  output logic                    ReadEn2,
  input  logic signed [RES_W-1:0] ConvResult,
  output logic signed [RES_W-1:0] result,
  output logic                    result_valid
);

  import cnn_pkg::*;

  localparam int WAIT_W = 8;

  seq_state_t state_q, state_d;

  // tap counter shared by both layers
  logic [ADDR_W:0]   tap_limit;
  logic [ADDR_W-1:0] tap_idx;
  logic              tap_last;
  logic              tap_clear;
  logic              tap_en;

  // settle / result-latency wait counter
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [WAIT_W-1:0] wait_len;
  logic              wait_last;
  logic              in_read;

  // address generation
  logic [ADDR_W+1:0] lead_raw, lead_max;
  logic [ADDR_W-1:0] lead_addr;

  // registered datapath outputs
  logic                    start1_q, start1_d;
  logic [IMG_W-1:0]        image_q, image_d;
  logic signed [F1_W-1:0]  filter1_q, filter1_d;
  logic                    start2_q, start2_d;
  logic signed [F2_W-1:0]  filter2_q, filter2_d;
  logic signed [RES_W-1:0] result_q, result_d;
  logic                    result_valid_q, result_valid_d;

  assign tap_limit = (state_q inside {S_L2_PRE, S_L2_RUN}) ? (ADDR_W+1)'(L2_TAPS)
                                                           : (ADDR_W+1)'(L1_TAPS);
  assign tap_clear = !(state_q inside {S_L1_RUN, S_L2_RUN});
  assign tap_en    = !tap_clear;

  cnn_tap_counter #(
    .CNT_W (ADDR_W)
  ) u_tap_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tap_clear),
    .enable (tap_en),
    .limit  (tap_limit),
    .count  (tap_idx),
    .last   (tap_last)
  );

  assign in_read   = state_q inside {S_L1_READ, S_L2_READ};
  assign wait_len  = (state_q == S_L2_READ) ? WAIT_W'(RES_LAT) : WAIT_W'(SETTLE1);
  assign wait_last = (wait_q == (wait_len - 1'b1));
  assign wait_d    = in_read ? (wait_q + 1'b1) : '0;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (go && !abort) state_d = S_L1_PRE;
      S_L1_PRE:   state_d = S_L1_RUN;
      S_L1_RUN:   if (tap_last) state_d = S_L1_FLUSH;
      S_L1_FLUSH: state_d = S_L1_READ;
      S_L1_READ:  if (wait_last) state_d = S_L2_PRE;
      S_L2_PRE:   state_d = S_L2_RUN;
      S_L2_RUN:   if (tap_last) state_d = S_L2_FLUSH;
      S_L2_FLUSH: state_d = S_L2_READ;
      S_L2_READ:  if (wait_last) state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end
  end

  // Output logic.
  // The tap registers sample rdata one cycle after the address, and the
  // address is issued one cycle before the PRE state (IDLE/READ drive 0).
  // So the address runs two taps ahead of the run index: 1 in PRE, k+2 in
  // run cycle k, saturating at TAPS-1. That keeps output tap k == mem[k].
  always_comb begin
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE);
    ReadEn1 = state_q inside {S_L1_READ, S_L2_PRE, S_L2_RUN, S_L2_FLUSH, S_L2_READ};
    ReadEn2 = (state_q == S_L2_READ);

    lead_max = {1'b0, tap_limit} - 1'b1;
    if (state_q inside {S_L1_PRE, S_L2_PRE}) begin
      lead_raw = (ADDR_W+2)'(1);
    end else begin
      lead_raw = {2'b00, tap_idx} + (ADDR_W+2)'(2);
    end
    lead_addr = (lead_raw > lead_max) ? lead_max[ADDR_W-1:0] : lead_raw[ADDR_W-1:0];

    img_addr = (state_q inside {S_L1_PRE, S_L1_RUN}) ? lead_addr : '0;
    f1_addr  = img_addr;
    f2_addr  = (state_q inside {S_L2_PRE, S_L2_RUN}) ? lead_addr : '0;

    start1_d  = (state_d == S_L1_RUN);
    image_d   = start1_d ? img_rdata : '0;
    filter1_d = start1_d ? f1_rdata  : '0;
    start2_d  = (state_d == S_L2_RUN);
    filter2_d = start2_d ? f2_rdata  : '0;

    result_d       = result_q;
    result_valid_d = result_valid_q;
    if (state_q == S_IDLE) begin
      if (go && !abort) result_valid_d = 1'b0;
    end else if (abort) begin
      result_valid_d = 1'b0;
    end else if ((state_q == S_L2_READ) && wait_last) begin
      result_d       = ConvResult;
      result_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start1_q       <= 1'b0;
      image_q        <= '0;
      filter1_q      <= '0;
      start2_q       <= 1'b0;
      filter2_q      <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      start1_q       <= start1_d;
      image_q        <= image_d;
      filter1_q      <= filter1_d;
      start2_q       <= start2_d;
      filter2_q      <= filter2_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign Start1       = start1_q;
  assign Image        = image_q;
  assign Filter1      = filter1_q;
  assign Start2       = start2_q;
  assign Filter2      = filter2_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_cnn_two_layer_seq.sv
// Directed bench for cnn_two_layer_seq: instance A at default parameters,
// instance B with L1_TAPS=9, L2_TAPS=4, SETTLE1=3, RES_LAT=1.
module tb_cnn_two_layer_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  // instance A
  logic        go_a, abort_a, busy_a, done_a, start1_a, readen1_a, start2_a, readen2_a, rv_a;
  logic [3:0]  img_addr_a, f1_addr_a, f2_addr_a, img_rdata_a, f1_rdata_a, image_a, filter1_a;
  logic [9:0]  f2_rdata_a, filter2_a;
  logic [21:0] conv_a, result_a;
  // instance B
  logic        go_b, abort_b, busy_b, done_b, start1_b, readen1_b, start2_b, readen2_b, rv_b;
  logic [3:0]  img_addr_b, f1_addr_b, f2_addr_b, img_rdata_b, f1_rdata_b, image_b, filter1_b;
  logic [9:0]  f2_rdata_b, filter2_b;
  logic [21:0] conv_b, result_b;

  logic [3:0] img_mem [16];
  logic [3:0] f1_mem  [16];
  logic [9:0] f2_mem  [16];

  always @(posedge clk) begin
    img_rdata_a <= img_mem[img_addr_a];
    f1_rdata_a  <= f1_mem[f1_addr_a];
    f2_rdata_a  <= f2_mem[f2_addr_a];
    img_rdata_b <= img_mem[img_addr_b];
    f1_rdata_b  <= f1_mem[f1_addr_b];
    f2_rdata_b  <= f2_mem[f2_addr_b];
  end

  cnn_two_layer_seq dut_a (
    .clk(clk), .rst_n(rst_n), .go(go_a), .abort(abort_a), .busy(busy_a), .done(done_a),
    .img_addr(img_addr_a), .img_rdata(img_rdata_a), .f1_addr(f1_addr_a), .f1_rdata(f1_rdata_a),
    .f2_addr(f2_addr_a), .f2_rdata(f2_rdata_a), .Start1(start1_a), .Image(image_a),
    .Filter1(filter1_a), .ReadEn1(readen1_a), .Start2(start2_a), .Filter2(filter2_a),
    .ReadEn2(readen2_a), .ConvResult(conv_a), .result(result_a), .result_valid(rv_a)
  );

  cnn_two_layer_seq #(
    .L1_TAPS(9), .L2_TAPS(4), .SETTLE1(3), .RES_LAT(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .go(go_b), .abort(abort_b), .busy(busy_b), .done(done_b),
    .img_addr(img_addr_b), .img_rdata(img_rdata_b), .f1_addr(f1_addr_b), .f1_rdata(f1_rdata_b),
    .f2_addr(f2_addr_b), .f2_rdata(f2_rdata_b), .Start1(start1_b), .Image(image_b),
    .Filter1(filter1_b), .ReadEn1(readen1_b), .Start2(start2_b), .Filter2(filter2_b),
    .ReadEn2(readen2_b), .ConvResult(conv_b), .result(result_b), .result_valid(rv_b)
  );

  // Expected {busy,done,Start1,Image,Filter1,ReadEn1,Start2,Filter2,ReadEn2}
  // in cycle c after go was sampled in cycle 0.
  function automatic logic [23:0] exp_vec(int c, int t1, int t2, int s, int r);
    int l2r_beg = t1 + 4 + s;
    int l2r_end = t1 + 3 + s + t2;
    int rd2_beg = t1 + 5 + s + t2;
    int dn      = t1 + 5 + s + t2 + r;
    logic b, d, s1, re1, s2, re2;
    logic [3:0] im, f1;
    logic [9:0] f2;
    b   = (c >= 1) && (c <= dn);
    d   = (c == dn);
    s1  = (c >= 2) && (c <= t1 + 1);
    im  = s1 ? img_mem[c-2] : 4'h0;
    f1  = s1 ? f1_mem[c-2]  : 4'h0;
    re1 = (c >= t1 + 3) && (c < dn);
    re2 = (c >= rd2_beg) && (c < dn);
    s2  = (c >= l2r_beg) && (c <= l2r_end);
    f2  = s2 ? f2_mem[c-l2r_beg] : 10'h0;
    return {b, d, s1, im, f1, re1, s2, f2, re2};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({busy_a, done_a, start1_a, image_a, filter1_a, readen1_a, start2_a, filter2_a, readen2_a,
         img_addr_a, f1_addr_a, f2_addr_a, result_a, rv_a} !== '0) begin
      errors++;
      $display("FAIL reset_a: outputs not all zero (busy=%b start1=%b result=%h rv=%b)",
               busy_a, start1_a, result_a, rv_a);
    end
    checks++;
    if ({busy_b, done_b, start1_b, image_b, filter1_b, readen1_b, start2_b, filter2_b, readen2_b,
         img_addr_b, f1_addr_b, f2_addr_b, result_b, rv_b} !== '0) begin
      errors++;
      $display("FAIL reset_b: outputs not all zero (busy=%b start1=%b result=%h rv=%b)",
               busy_b, start1_b, result_b, rv_b);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if ({busy_a, done_a, start1_a, readen1_a, rv_a} !== 5'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got %b want 00000", {busy_a, done_a, start1_a, readen1_a, rv_a});
    end
  endtask

  task automatic test_nominal();
    int s1_first = -1, s1_last = -1, s2_first = -1, s2_last = -1, dn_cyc = -1;
    logic [23:0] obs, exp;
    go_a = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      go_a   = 1'b0;
      conv_a = (c == 37) ? 22'h1234 : 22'h0;
      obs = {busy_a, done_a, start1_a, image_a, filter1_a, readen1_a, start2_a, filter2_a, readen2_a};
      exp = exp_vec(c, 15, 15, 1, 2);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL nominal_outputs cycle %0d: got %h want %h", c, obs, exp);
      end
      if (start1_a) begin if (s1_first < 0) s1_first = c; s1_last = c; end
      if (start2_a) begin if (s2_first < 0) s2_first = c; s2_last = c; end
      if (done_a && dn_cyc < 0) dn_cyc = c;
      checks++;
      if (c >= 38) begin
        if ({rv_a, result_a} !== {1'b1, 22'h1234}) begin
          errors++;
          $display("FAIL result_capture cycle %0d: got rv=%b result=%h want rv=1 result=1234", c, rv_a, result_a);
        end
      end else if (rv_a !== 1'b0) begin
        errors++;
        $display("FAIL result_valid_early cycle %0d: got %b want 0", c, rv_a);
      end
    end
    checks++;
    if ({s1_first, s1_last, s2_first, s2_last, dn_cyc} !== {32'sd2, 32'sd16, 32'sd20, 32'sd34, 32'sd38}) begin
      errors++;
      $display("FAIL nominal_timing: Start1 %0d..%0d Start2 %0d..%0d done %0d want 2..16 20..34 38",
               s1_first, s1_last, s2_first, s2_last, dn_cyc);
    end
    repeat (10) tick();
    checks++;
    if ({rv_a, result_a} !== {1'b1, 22'h1234}) begin
      errors++;
      $display("FAIL result_hold: got rv=%b result=%h want rv=1 result=1234", rv_a, result_a);
    end
  endtask

  task automatic test_go_while_busy();
    int dn_count = 0, dn_cyc = -1;
    go_a = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      tick();
      go_a = (c == 5) || (c == 38);
      if (c == 1) begin
        checks++;
        if (rv_a !== 1'b0) begin
          errors++;
          $display("FAIL go_clears_valid: got %b want 0", rv_a);
        end
      end
      if (done_a) begin dn_count++; if (dn_cyc < 0) dn_cyc = c; end
    end
    go_a = 1'b0;
    checks++;
    if (dn_count != 1 || dn_cyc != 38) begin
      errors++;
      $display("FAIL go_while_busy: got %0d done pulses first at %0d want 1 at 38", dn_count, dn_cyc);
    end
  endtask

  task automatic test_abort();
    int dn_count = 0, s1_count = 0, dn_cyc = -1;
    go_a = 1'b1;
    for (int c = 1; c <= 26; c++) begin
      tick();
      go_a    = 1'b0;
      abort_a = (c == 25);
      if (c == 25) begin
        checks++;
        if (start2_a !== 1'b1) begin
          errors++;
          $display("FAIL abort_pre: Start2 got %b want 1 in cycle 25", start2_a);
        end
      end
    end
    checks++;
    if ({busy_a, start2_a, readen1_a, rv_a, done_a, f2_addr_a} !== 9'b0) begin
      errors++;
      $display("FAIL abort_idle: busy=%b Start2=%b ReadEn1=%b rv=%b done=%b f2_addr=%h want all 0",
               busy_a, start2_a, readen1_a, rv_a, done_a, f2_addr_a);
    end
    for (int c = 0; c < 30; c++) begin
      tick();
      if (done_a) dn_count++;
    end
    checks++;
    if (dn_count != 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d done pulses want 0", dn_count);
    end
    go_a = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      go_a = 1'b0;
      if (start1_a) s1_count++;
      if (done_a && dn_cyc < 0) dn_cyc = c;
    end
    checks++;
    if (s1_count != 15 || dn_cyc != 38 || rv_a !== 1'b1) begin
      errors++;
      $display("FAIL abort_rerun: Start1 count %0d done at %0d rv=%b want 15 38 1", s1_count, dn_cyc, rv_a);
    end
  endtask

  task automatic test_reset_mid();
    int dn_count = 0;
    go_a = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      tick();
      go_a  = 1'b0;
      rst_n = (c != 10);
    end
    checks++;
    if ({busy_a, done_a, start1_a, image_a, filter1_a, readen1_a, start2_a, filter2_a, readen2_a,
         img_addr_a, f1_addr_a, f2_addr_a, result_a, rv_a} !== '0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b start1=%b image=%h img_addr=%h result=%h rv=%b want all 0",
               busy_a, start1_a, image_a, img_addr_a, result_a, rv_a);
    end
    for (int c = 0; c < 40; c++) begin
      tick();
      if (done_a) dn_count++;
    end
    checks++;
    if (dn_count != 0) begin
      errors++;
      $display("FAIL reset_no_done: got %0d done pulses want 0", dn_count);
    end
    go_a    = 1'b1;
    abort_a = 1'b1;
    tick();
    go_a    = 1'b0;
    abort_a = 1'b0;
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("FAIL go_abort_idle: busy got %b want 0", busy_a);
    end
    tick();
    tick();
    checks++;
    if ({busy_a, start1_a, img_addr_a} !== 6'b0) begin
      errors++;
      $display("FAIL go_abort_stays_idle: got %b want 000000", {busy_a, start1_a, img_addr_a});
    end
  endtask

  task automatic test_small_params();
    int s1_count = 0, s2_count = 0, dn_cyc = -1, re1_pre = 0;
    logic seen_f2 = 1'b0;
    logic [23:0] obs, exp;
    go_b = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      go_b = 1'b0;
      obs = {busy_b, done_b, start1_b, image_b, filter1_b, readen1_b, start2_b, filter2_b, readen2_b};
      exp = exp_vec(c, 9, 4, 3, 1);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL small_outputs cycle %0d: got %h want %h", c, obs, exp);
      end
      if (f2_addr_b != 4'h0 || start2_b) seen_f2 = 1'b1;
      if (readen1_b && !seen_f2) re1_pre++;
      if (start1_b) s1_count++;
      if (start2_b) s2_count++;
      if (done_b && dn_cyc < 0) dn_cyc = c;
    end
    checks++;
    if (s1_count != 9 || s2_count != 4 || dn_cyc != 22 || re1_pre != 3) begin
      errors++;
      $display("FAIL small_params: Start1 %0d Start2 %0d done %0d ReadEn1-before-L2 %0d want 9 4 22 3",
               s1_count, s2_count, dn_cyc, re1_pre);
    end
  endtask

  initial begin
    int img_init [15] = '{1, 2, 3, 2, 3, 4, 3, 4, 5, 4, 5, 6, 5, 6, 7};
    int f1_init  [15] = '{1, 2, 3, -3, -2, -1, 1, 2, 3, -5, 5, -7, 1, 2, 3};
    int f2_init  [15] = '{1, 2, 3, -1, -2, -3, 4, 5, 6, -4, -5, -6, 7, 8, 9};
    for (int i = 0; i < 16; i++) begin
      img_mem[i] = 4'h0;
      f1_mem[i]  = 4'h0;
      f2_mem[i]  = 10'h0;
    end
    for (int i = 0; i < 15; i++) begin
      img_mem[i] = 4'(img_init[i]);
      f1_mem[i]  = 4'(f1_init[i]);
      f2_mem[i]  = 10'(f2_init[i]);
    end
    go_a = 1'b0; abort_a = 1'b0; conv_a = '0;
    go_b = 1'b0; abort_b = 1'b0; conv_b = '0;
    rst_n = 1'b0;

    test_reset();
    test_nominal();
    test_go_while_busy();
    test_abort();
    test_reset_mid();
    test_small_params();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
